// File: rtl/inst_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : inst_trace_fifo
//  Purpose  : Commit-side instruction trace buffer. Captures up to two retired
//             instructions per cycle and replays them one per cycle, in
//             program order, over a first-word-fall-through valid/ready port.
//             Tracks commits lost to a full buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_trace_fifo #(
    parameter int  DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             freeze,
    input  logic             c0_valid,
    input  logic [31:0]      c0_pc,
    input  logic [31:0]      c0_instr,
    input  logic             c1_valid,
    input  logic [31:0]      c1_pc,
    input  logic [31:0]      c1_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] count,
    output logic [15:0]      drop_cnt,
    output logic             overflow
);

    localparam int               c_ptr_w = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    // Storage (intentionally not reset; only read while count != 0)
    logic [31:0]        r_mem_pc    [DEPTH];
    logic [31:0]        r_mem_instr [DEPTH];

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [15:0]        r_drop_cnt;
    logic               r_overflow;

    logic               w_push0;
    logic               w_push1;
    logic [1:0]         w_n_req;
    logic [1:0]         w_n_acc;
    logic [1:0]         w_n_drop;
    logic [CNT_W-1:0]   w_free;
    logic               w_nonempty;
    logic               w_pop;
    logic               w_flush;
    logic [31:0]        w_wr_pc0;
    logic [31:0]        w_wr_instr0;
    logic [c_ptr_w-1:0] w_wr_ptr1;
    logic [CNT_W-1:0]   w_count_next;
    logic [16:0]        w_drop_sum;
    logic [15:0]        w_drop_next;

    // Admission: free space is judged on start-of-cycle count, so a same-cycle
    // pop never makes room for this cycle's commits. Oldest slots win.
    always_comb begin
        w_flush     = !resetn || clear;
        w_push0     = c0_valid && !freeze;
        w_push1     = c1_valid && !freeze;
        w_n_req     = {1'b0, w_push0} + {1'b0, w_push1};
        w_free      = c_depth - r_count;
        w_n_acc     = w_n_req;
        if (w_free == '0) begin
            w_n_acc = 2'd0;
        end else if (w_free == CNT_W'(1) && w_n_req == 2'd2) begin
            w_n_acc = 2'd1;
        end
        w_n_drop    = w_n_req - w_n_acc;
        // The first written entry is slot 0 if it pushes, otherwise slot 1 alone
        w_wr_pc0    = w_push0 ? c0_pc    : c1_pc;
        w_wr_instr0 = w_push0 ? c0_instr : c1_instr;
        w_wr_ptr1   = r_wr_ptr + c_ptr_w'(1);
        w_nonempty  = (r_count != '0);
        w_pop       = w_nonempty && out_ready;
        w_count_next = r_count + {{(CNT_W-2){1'b0}}, w_n_acc}
                               - {{(CNT_W-1){1'b0}}, w_pop};
        w_drop_sum  = {1'b0, r_drop_cnt} + {15'd0, w_n_drop};
        w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    // Write accepted commits into storage; discarded while flushing
    always_ff @(posedge clk) begin
        if (!w_flush) begin
            if (w_n_acc != 2'd0) begin
                r_mem_pc[r_wr_ptr]    <= w_wr_pc0;
                r_mem_instr[r_wr_ptr] <= w_wr_instr0;
            end
            if (w_n_acc == 2'd2) begin
                r_mem_pc[w_wr_ptr1]    <= c1_pc;
                r_mem_instr[w_wr_ptr1] <= c1_instr;
            end
        end
    end

    // Pointer, occupancy and drop statistics; reset and clear both flush
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + c_ptr_w'(w_n_acc);
            r_rd_ptr   <= r_rd_ptr + c_ptr_w'(w_pop);
            r_count    <= w_count_next;
            r_drop_cnt <= w_drop_next;
            if (w_n_drop != 2'd0) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_valid = w_nonempty;
    assign out_pc    = w_nonempty ? r_mem_pc[r_rd_ptr]    : 32'd0;
    assign out_instr = w_nonempty ? r_mem_instr[r_rd_ptr] : 32'd0;
    assign count     = r_count;
    assign drop_cnt  = r_drop_cnt;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_inst_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_trace_fifo
//  Purpose  : Self-checking bench for inst_trace_fifo against a queue-based
//             reference model; directed scenarios then randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_trace_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn, clear, freeze;
    logic          c0_valid, c1_valid, out_ready;
    logic [31:0]   c0_pc, c0_instr, c1_pc, c1_instr;
    logic          out_valid;
    logic [31:0]   out_pc, out_instr;
    logic [CW-1:0] count;
    logic [15:0]   drop_cnt;
    logic          overflow;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t mq[$];
    int   m_drop;
    bit   m_ovf;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] seq_pc;

    always #5 clk = ~clk;

    inst_trace_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .clear(clear), .freeze(freeze),
        .c0_valid(c0_valid), .c0_pc(c0_pc), .c0_instr(c0_instr),
        .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_instr(c1_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .count(count), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a queue; admission limited by space before the pop
    task automatic model_update();
        ent_t req[$];
        int   free_n;
        ent_t e;
        if (!resetn || clear) begin
            mq.delete();
            m_drop = 0;
            m_ovf  = 0;
            return;
        end
        free_n = DEPTH - mq.size();
        if (c0_valid && !freeze) begin e.pc = c0_pc; e.ins = c0_instr; req.push_back(e); end
        if (c1_valid && !freeze) begin e.pc = c1_pc; e.ins = c1_instr; req.push_back(e); end
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        foreach (req[k]) begin
            if (k < free_n) mq.push_back(req[k]);
            else begin
                m_drop = (m_drop >= 16'hFFFF) ? 16'hFFFF : m_drop + 1;
                m_ovf  = 1;
            end
        end
    endtask

    task automatic check_all();
        bit ne;
        ne = (mq.size() != 0);
        check_val("out_valid", {63'd0, out_valid}, {63'd0, ne});
        check_val("out_pc",    {32'd0, out_pc},    ne ? {32'd0, mq[0].pc}  : 64'd0);
        check_val("out_instr", {32'd0, out_instr}, ne ? {32'd0, mq[0].ins} : 64'd0);
        check_val("count",     64'(count),         64'(mq.size()));
        check_val("drop_cnt",  {48'd0, drop_cnt},  64'(m_drop));
        check_val("overflow",  {63'd0, overflow},  {63'd0, m_ovf});
    endtask

    // Inputs are set at the falling edge; model advances, then outputs checked
    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        resetn = 1; clear = 0; freeze = 0; out_ready = 0;
        c0_valid = 0; c1_valid = 0;
        c0_pc = 0; c0_instr = 0; c1_pc = 0; c1_instr = 0;
    endtask

    task automatic commit(input bit v0, input logic [31:0] p0, input bit v1, input logic [31:0] p1);
        c0_valid = v0; c0_pc = p0; c0_instr = p0 ^ 32'hA5A5_0000;
        c1_valid = v1; c1_pc = p1; c1_instr = p1 ^ 32'h5A5A_0000;
    endtask

    initial begin
        m_drop = 0; m_ovf = 0; seq_pc = 32'h1000;
        idle();
        resetn = 0;
        @(negedge clk);
        step();
        step();
        resetn = 1;

        // First commit visible one cycle later
        c0_valid = 1; c0_pc = 32'hBFC00000; c0_instr = 32'h24080001;
        step();
        check_val("t1_pc",    {32'd0, out_pc},    64'h0000_0000_BFC0_0000);
        check_val("t1_instr", {32'd0, out_instr}, 64'h0000_0000_2408_0001);
        check_val("t1_count", 64'(count), 64'd1);
        idle(); out_ready = 1; step();

        // Dual commit then in-order drain
        commit(1, 32'h100, 1, 32'h104); out_ready = 1; step();
        check_val("t2_head", {32'd0, out_pc}, 64'h100);
        commit(0, 0, 0, 0); step();
        check_val("t2_next", {32'd0, out_pc}, 64'h104);
        step();

        // Fill to 3 then dual commit: one stored, one dropped
        out_ready = 0;
        commit(1, 32'h10, 1, 32'h14); step();
        commit(1, 32'h18, 0, 0);      step();
        commit(1, 32'h1C, 1, 32'h20); step();
        check_val("t3_count", 64'(count), 64'd4);
        check_val("t3_drop",  {48'd0, drop_cnt}, 64'd1);
        // Full with pop and dual commit: both dropped
        commit(1, 32'h24, 1, 32'h28); out_ready = 1; step();
        check_val("t4_count", 64'(count), 64'd3);
        check_val("t4_drop",  {48'd0, drop_cnt}, 64'd3);

        // Clear on non-empty buffer
        commit(1, 32'h30, 1, 32'h34); clear = 1; step();
        check_val("t6_count", 64'(count), 64'd0);
        clear = 0;

        // Slot 1 alone on empty buffer
        out_ready = 0; commit(0, 0, 1, 32'h200); step();
        check_val("t5_head", {32'd0, out_pc}, 64'h200);

        // Freeze: commits ignored, draining continues
        freeze = 1; out_ready = 1;
        for (int i = 0; i < 4; i++) begin commit(1, 32'h300 + i, 1, 32'h400 + i); step(); end
        freeze = 0;

        // Streaming across pointer wrap with sequential pcs
        for (int i = 0; i < 60; i++) begin
            commit($urandom_range(0, 1), seq_pc, $urandom_range(0, 1), seq_pc + 4);
            seq_pc += 8;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Fully random traffic including occasional clear, freeze and reset
        for (int i = 0; i < 600; i++) begin
            commit($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            freeze    = ($urandom_range(0, 7) == 0);
            clear     = ($urandom_range(0, 47) == 0);
            resetn    = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
